// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, branch funct3 codes, reset values
// and the operand forwarding selector.
package id_stage_pkg;

    localparam logic [63:0] PC_ENTRY = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LUI       = 7'b0110111,
        OPC_AUIPC     = 7'b0010111,
        OPC_JAL       = 7'b1101111,
        OPC_JALR      = 7'b1100111,
        OPC_BRANCH    = 7'b1100011,
        OPC_LOAD      = 7'b0000011,
        OPC_STORE     = 7'b0100011,
        OPC_OP_IMM    = 7'b0010011,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_OP        = 7'b0110011,
        OPC_OP_32     = 7'b0111011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    // Youngest producer wins; a nonzero address already guarantees dest != x0.
    function automatic logic [63:0] fwd_pick(
        input logic [4:0]  addr,
        input logic [63:0] rf_data,
        input logic        es_v,
        input logic [4:0]  es_d,
        input logic [63:0] es_x,
        input logic        ms_v,
        input logic [4:0]  ms_d,
        input logic [63:0] ms_x,
        input logic        ws_v,
        input logic [4:0]  ws_d,
        input logic [63:0] ws_x
    );
        if (addr == 5'd0)               return '0;
        if (es_v && (es_d == addr))     return es_x;
        if (ms_v && (ms_d == addr))     return ms_x;
        if (ws_v && (ws_d == addr))     return ws_x;
        return rf_data;
    endfunction

endpackage

// File: rtl/id_stage_br_unit.sv
// Branch condition evaluation and redirect target generation for the decode stage.
module id_br_unit
    import id_stage_pkg::*;
(
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic [2:0]  funct3,
    input  logic [63:0] pc,
    input  logic [63:0] rs1_val,
    input  logic [63:0] rs2_val,
    input  logic [63:0] imm,
    output logic        take,
    output logic [63:0] target
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1_val == rs2_val);
            F3_BNE:  cond = (rs1_val != rs2_val);
            F3_BLT:  cond = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: cond = (rs1_val <  rs2_val);
            F3_BGEU: cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
    end

    assign take   = is_jal || is_jalr || (is_branch && cond);
    assign target = is_jalr ? ((rs1_val + imm) & ~64'h1) : (pc + imm);

endmodule

// File: rtl/id_stage.sv
// Decode stage: holds one instruction, forwards operands, builds the immediate,
// detects load-use hazards and issues a one-cycle redirect in the handoff cycle.
module id_stage
    import id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_to_ds_valid,
    input  logic [63:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        ds_allow_in,
    input  logic        id_inst_cancel,
    input  logic        wb_flush,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [63:0] rf_rdata1,
    input  logic [63:0] rf_rdata2,
    input  logic        es_fwd_valid,
    input  logic        ms_fwd_valid,
    input  logic        ws_fwd_valid,
    input  logic [4:0]  es_dest,
    input  logic [4:0]  ms_dest,
    input  logic [4:0]  ws_dest,
    input  logic [63:0] es_data,
    input  logic [63:0] ms_data,
    input  logic [63:0] ws_data,
    input  logic        es_is_load,
    output logic        ds_to_es_valid,
    input  logic        es_allow_in,
    output logic [63:0] ds_pc,
    output logic [31:0] ds_inst,
    output logic [63:0] ds_rs1_val,
    output logic [63:0] ds_rs2_val,
    output logic [63:0] ds_imm,
    output logic        br_taken,
    output logic [63:0] br_target
);

    logic        ds_valid_q, ds_valid_d;
    logic [63:0] ds_pc_q,    ds_pc_d;
    logic [31:0] ds_inst_q,  ds_inst_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_used, rs2_used, load_use, ds_ready_go;
    logic        is_branch, is_jal, is_jalr, br_take;
    logic [63:0] rs1_val, rs2_val, imm;

    assign opcode    = ds_inst_q[6:0];
    assign rs1_addr  = ds_inst_q[19:15];
    assign rs2_addr  = ds_inst_q[24:20];
    assign rf_raddr1 = rs1_addr;
    assign rf_raddr2 = rs2_addr;

    assign rs1_val = fwd_pick(rs1_addr, rf_rdata1, es_fwd_valid, es_dest, es_data,
                              ms_fwd_valid, ms_dest, ms_data, ws_fwd_valid, ws_dest, ws_data);
    assign rs2_val = fwd_pick(rs2_addr, rf_rdata2, es_fwd_valid, es_dest, es_data,
                              ms_fwd_valid, ms_dest, ms_data, ws_fwd_valid, ws_dest, ws_data);

    assign rs1_used = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign rs2_used =  (opcode inside {OPC_OP, OPC_OP_32, OPC_BRANCH, OPC_STORE});

    assign load_use = es_is_load && es_fwd_valid && (es_dest != 5'd0) &&
                      ((rs1_used && (es_dest == rs1_addr)) ||
                       (rs2_used && (es_dest == rs2_addr)));

    assign ds_ready_go    = !load_use;
    assign ds_allow_in    = !ds_valid_q || (ds_ready_go && es_allow_in);
    assign ds_to_es_valid = ds_valid_q && ds_ready_go && !wb_flush;

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR:
                imm = {{52{ds_inst_q[31]}}, ds_inst_q[31:20]};
            OPC_STORE:
                imm = {{52{ds_inst_q[31]}}, ds_inst_q[31:25], ds_inst_q[11:7]};
            OPC_BRANCH:
                imm = {{52{ds_inst_q[31]}}, ds_inst_q[7], ds_inst_q[30:25],
                       ds_inst_q[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {{32{ds_inst_q[31]}}, ds_inst_q[31:12], 12'b0};
            OPC_JAL:
                imm = {{44{ds_inst_q[31]}}, ds_inst_q[19:12], ds_inst_q[20],
                       ds_inst_q[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);

    id_br_unit u_br_unit (
        .is_branch (is_branch),
        .is_jal    (is_jal),
        .is_jalr   (is_jalr),
        .funct3    (ds_inst_q[14:12]),
        .pc        (ds_pc_q),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .imm       (imm),
        .take      (br_take),
        .target    (br_target)
    );

    // Redirect only in the cycle the instruction actually leaves for EX.
    assign br_taken = ds_valid_q && ds_ready_go && es_allow_in && !wb_flush && br_take;

    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (ds_allow_in) begin
            ds_valid_d = fs_to_ds_valid && !id_inst_cancel;
            if (fs_to_ds_valid) begin
                ds_pc_d   = fs_pc;
                ds_inst_d = fs_inst;
            end
        end
        if (wb_flush) begin
            ds_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= '0;
            ds_inst_q  <= NOP_INST;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end

    assign ds_pc      = ds_pc_q;
    assign ds_inst    = ds_inst_q;
    assign ds_rs1_val = rs1_val;
    assign ds_rs2_val = rs2_val;
    assign ds_imm     = imm;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: table of single-instruction decodes scored at the
// EX handoff, plus hand sequences for load-use, backpressure, flush, cancel and reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_to_ds_valid;
    logic [63:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allow_in;
    logic        id_inst_cancel;
    logic        wb_flush;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [63:0] rf_rdata1, rf_rdata2;
    logic        es_fwd_valid, ms_fwd_valid, ws_fwd_valid;
    logic [4:0]  es_dest, ms_dest, ws_dest;
    logic [63:0] es_data, ms_data, ws_data;
    logic        es_is_load;
    logic        ds_to_es_valid;
    logic        es_allow_in;
    logic [63:0] ds_pc;
    logic [31:0] ds_inst;
    logic [63:0] ds_rs1_val, ds_rs2_val, ds_imm;
    logic        br_taken;
    logic [63:0] br_target;

    always #5 clk = ~clk;

    logic [63:0] rf [32];
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst),
        .ds_allow_in    (ds_allow_in),
        .id_inst_cancel (id_inst_cancel),
        .wb_flush       (wb_flush),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .es_fwd_valid   (es_fwd_valid),
        .ms_fwd_valid   (ms_fwd_valid),
        .ws_fwd_valid   (ws_fwd_valid),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_dest        (ws_dest),
        .es_data        (es_data),
        .ms_data        (ms_data),
        .ws_data        (ws_data),
        .es_is_load     (es_is_load),
        .ds_to_es_valid (ds_to_es_valid),
        .es_allow_in    (es_allow_in),
        .ds_pc          (ds_pc),
        .ds_inst        (ds_inst),
        .ds_rs1_val     (ds_rs1_val),
        .ds_rs2_val     (ds_rs2_val),
        .ds_imm         (ds_imm),
        .br_taken       (br_taken),
        .br_target      (br_target)
    );

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  wa1;
        logic [63:0] wv1;
        logic [4:0]  wa2;
        logic [63:0] wv2;
        logic [2:0]  fv;
        logic [4:0]  fdest;
        logic [63:0] fd_es, fd_ms, fd_ws;
        logic        chk_ops;
        logic [63:0] rs1, rs2, imm;
        logic        taken;
        logic        chk_tgt;
        logic [63:0] target;
    } vec_t;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        chk_ops;
        logic [63:0] rs1, rs2, imm;
        logic        taken;
        logic        chk_tgt;
        logic [63:0] target;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int unsigned errors = 0;
    int unsigned checks = 0;
    vec_t        vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [6:0] op);
        return {im[11:5], rs2, rs1, f3, im[4:0], op};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd,
            input logic [6:0] op);
        return {im, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
    endfunction

    // Scoreboard: every handoff to EX must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (ds_to_es_valid && es_allow_in) begin
                chk("handoff_expected", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk({mon_e.name, "/pc"},    ds_pc,   mon_e.pc);
                    chk({mon_e.name, "/inst"},  64'(ds_inst), 64'(mon_e.inst));
                    chk({mon_e.name, "/imm"},   ds_imm,  mon_e.imm);
                    chk({mon_e.name, "/taken"}, 64'(br_taken), 64'(mon_e.taken));
                    if (mon_e.chk_ops) begin
                        chk({mon_e.name, "/rs1"}, ds_rs1_val, mon_e.rs1);
                        chk({mon_e.name, "/rs2"}, ds_rs2_val, mon_e.rs2);
                    end
                    if (mon_e.chk_tgt) chk({mon_e.name, "/target"}, br_target, mon_e.target);
                end
            end else begin
                chk("no_stray_br_taken", 64'(br_taken), 64'd0);
            end
        end
    end

    task automatic apply_vec(input vec_t v);
        exp_t e;
        if (v.wa1 != 5'd0) rf[v.wa1] = v.wv1;
        if (v.wa2 != 5'd0) rf[v.wa2] = v.wv2;
        es_fwd_valid = v.fv[2];
        ms_fwd_valid = v.fv[1];
        ws_fwd_valid = v.fv[0];
        es_dest = v.fdest;  ms_dest = v.fdest;  ws_dest = v.fdest;
        es_data = v.fd_es;  ms_data = v.fd_ms;  ws_data = v.fd_ws;
        fs_to_ds_valid = 1'b1;
        fs_pc   = v.pc;
        fs_inst = v.inst;
        e.name = v.name;  e.pc = v.pc;  e.inst = v.inst;  e.chk_ops = v.chk_ops;
        e.rs1 = v.rs1;  e.rs2 = v.rs2;  e.imm = v.imm;  e.taken = v.taken;
        e.chk_tgt = v.chk_tgt;  e.target = v.target;
        sb_q.push_back(e);
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clear_fwd();
        es_fwd_valid = 1'b0; ms_fwd_valid = 1'b0; ws_fwd_valid = 1'b0;
        es_dest = '0; ms_dest = '0; ws_dest = '0;
        es_data = '0; ms_data = '0; ws_data = '0;
        es_is_load = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        fs_to_ds_valid = 1'b0; fs_pc = '0; fs_inst = '0;
        id_inst_cancel = 1'b0; wb_flush = 1'b0; es_allow_in = 1'b1;
        clear_fwd();
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[0] = 64'hDEAD_BEEF_0000_0000;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("rst_br_taken",    64'(br_taken),       64'd0);
        chk("rst_allow_in",    64'(ds_allow_in),    64'd1);
        chk("rst_pc",          ds_pc,               64'd0);
        chk("rst_inst",        64'(ds_inst),        64'h13);

        vecs[0]  = '{"beq_taken", 64'h8000_0000, enc_b(13'd16, 5'd2, 5'd1, 3'b000), 5'd1, 64'd5, 5'd2, 64'd5,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd5, 64'd5, 64'd16, 1'b1, 1'b1, 64'h8000_0010};
        vecs[1]  = '{"bne_not_taken", 64'h8000_0000, enc_b(13'd16, 5'd2, 5'd1, 3'b001), 5'd1, 64'd5, 5'd2, 64'd5,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd5, 64'd5, 64'd16, 1'b0, 1'b1, 64'h8000_0010};
        vecs[2]  = '{"blt_signed", 64'h1000, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b100), 5'd1, M1, 5'd2, 64'd1,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, M1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b1, 64'h0FF8};
        vecs[3]  = '{"bltu_not_taken", 64'h1000, enc_b(13'h1FF8, 5'd2, 5'd1, 3'b110), 5'd1, M1, 5'd2, 64'd1,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, M1, 64'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b1, 64'h0FF8};
        vecs[4]  = '{"bge_equal", 64'h1000, enc_b(13'd8, 5'd2, 5'd1, 3'b101), 5'd1, M1, 5'd2, M1,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, M1, M1, 64'd8, 1'b1, 1'b1, 64'h1008};
        vecs[5]  = '{"bgeu_not_taken", 64'h1000, enc_b(13'd8, 5'd2, 5'd1, 3'b111), 5'd1, 64'd1, 5'd2, M1,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'd1, M1, 64'd8, 1'b0, 1'b1, 64'h1008};
        vecs[6]  = '{"jalr_bit0", 64'h3000, enc_i(12'hFFD, 5'd1, 3'b000, 5'd0, 7'h67), 5'd1, 64'h8000_0100, 5'd0, 64'd0,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h8000_0100, 64'h101D, 64'hFFFF_FFFF_FFFF_FFFD,
                     1'b1, 1'b1, 64'h8000_00FC};
        vecs[7]  = '{"jal", 64'h2000, enc_j(21'h800, 5'd1), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'h800, 1'b1, 1'b1, 64'h2800};
        vecs[8]  = '{"fwd_es", 64'h4000, enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'h13), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b111, 5'd7, 64'd1, 64'd2, 64'd3, 1'b1, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[9]  = '{"fwd_ms", 64'h4000, enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'h13), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b011, 5'd7, 64'd1, 64'd2, 64'd3, 1'b1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[10] = '{"fwd_ws", 64'h4000, enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'h13), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b001, 5'd7, 64'd1, 64'd2, 64'd3, 1'b1, 64'd3, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[11] = '{"fwd_regfile", 64'h4000, enc_i(12'd0, 5'd7, 3'b000, 5'd8, 7'h13), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b000, 5'd7, 64'd1, 64'd2, 64'd3, 1'b1, 64'h1007, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[12] = '{"x0_reads_zero", 64'h4004, enc_i(12'd5, 5'd0, 3'b000, 5'd8, 7'h13), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b111, 5'd0, 64'd1, 64'd2, 64'd3, 1'b1, 64'd0, 64'h1005, 64'd5, 1'b0, 1'b0, 64'd0};
        vecs[13] = '{"lui", 64'h4010, enc_u(20'h80000, 5'd5, 7'h37), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0, 64'd0};
        vecs[14] = '{"sd_store", 64'h4014, enc_s(12'hFFC, 5'd2, 5'd1, 3'b011, 7'h23), 5'd1, 64'h100, 5'd2, 64'h55,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h100, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'd0};
        vecs[15] = '{"add_fwd_rs2", 64'h4018, enc_r(7'd0, 5'd7, 5'd6, 3'b000, 5'd4, 7'h33), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b010, 5'd7, 64'd1, 64'd2, 64'd3, 1'b1, 64'h1006, 64'd2, 64'd0, 1'b0, 1'b0, 64'd0};
        vecs[16] = '{"addiw_neg1", 64'h401C, enc_i(12'hFFF, 5'd6, 3'b000, 5'd9, 7'h1B), 5'd0, 64'd0, 5'd0, 64'd0,
                     3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h1006, 64'h101F, M1, 1'b0, 1'b0, 64'd0};

        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) apply_vec(vecs[i]);

        // Load-use stall: one cycle held, then the value arrives from MEM.
        clear_fwd();
        rf[3] = 64'hBAD0; rf[5] = 64'h55;
        es_is_load = 1'b1; es_fwd_valid = 1'b1; es_dest = 5'd3; es_data = 64'h1234;
        fs_to_ds_valid = 1'b1; fs_pc = 64'h5000; fs_inst = enc_r(7'd0, 5'd5, 5'd3, 3'b000, 5'd4, 7'h33);
        @(posedge clk); #1;
        fs_pc = 64'h5004; fs_inst = 32'h0000_0013;
        @(negedge clk);
        chk("lu_allow_in",    64'(ds_allow_in),    64'd0);
        chk("lu_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("lu_held_pc",     ds_pc,               64'h5000);
        @(posedge clk); #1;
        es_is_load = 1'b0; es_fwd_valid = 1'b0;
        ms_fwd_valid = 1'b1; ms_dest = 5'd3; ms_data = 64'h1234;
        fs_to_ds_valid = 1'b0;
        e.name = "load_use_resolved"; e.pc = 64'h5000; e.inst = enc_r(7'd0, 5'd5, 5'd3, 3'b000, 5'd4, 7'h33);
        e.chk_ops = 1'b1; e.rs1 = 64'h1234; e.rs2 = 64'h55; e.imm = 64'd0; e.taken = 1'b0;
        e.chk_tgt = 1'b0; e.target = 64'd0;
        sb_q.push_back(e);
        @(posedge clk); #1;

        // JAL held by EX backpressure for three cycles; redirect only on release.
        clear_fwd();
        es_allow_in = 1'b0;
        fs_to_ds_valid = 1'b1; fs_pc = 64'h6000; fs_inst = enc_j(21'h800, 5'd1);
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_br_taken",    64'(br_taken),       64'd0);
            chk("bp_to_es_valid", 64'(ds_to_es_valid), 64'd1);
            chk("bp_allow_in",    64'(ds_allow_in),    64'd0);
            chk("bp_pc",          ds_pc,               64'h6000);
            chk("bp_target",      br_target,           64'h6800);
            @(posedge clk); #1;
        end
        es_allow_in = 1'b1;
        e.name = "jal_backpressure"; e.pc = 64'h6000; e.inst = enc_j(21'h800, 5'd1);
        e.chk_ops = 1'b0; e.rs1 = 64'd0; e.rs2 = 64'd0; e.imm = 64'h800; e.taken = 1'b1;
        e.chk_tgt = 1'b1; e.target = 64'h6800;
        sb_q.push_back(e);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_pulse_once", 64'(br_taken), 64'd0);

        // Flush in the same cycle as a new fetch: nothing survives, no redirect.
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b1; fs_pc = 64'h7000; fs_inst = enc_j(21'h10, 5'd0);
        @(posedge clk); #1;
        fs_pc = 64'h7004; fs_inst = enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'h13);
        wb_flush = 1'b1;
        @(negedge clk);
        chk("fl_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("fl_br_taken",    64'(br_taken),       64'd0);
        @(posedge clk); #1;
        wb_flush = 1'b0; fs_to_ds_valid = 1'b0;
        @(negedge clk);
        chk("fl_dropped_valid", 64'(ds_to_es_valid), 64'd0);
        chk("fl_allow_in",      64'(ds_allow_in),    64'd1);

        // Fetch-side cancel drops the instruction being accepted.
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b1; id_inst_cancel = 1'b1; fs_pc = 64'h7100; fs_inst = enc_j(21'h10, 5'd0);
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b0; id_inst_cancel = 1'b0;
        @(negedge clk);
        chk("cancel_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("cancel_br_taken",    64'(br_taken),       64'd0);

        // Reset while stalled discards the held instruction.
        @(posedge clk); #1;
        es_is_load = 1'b1; es_fwd_valid = 1'b1; es_dest = 5'd3; es_data = 64'h9;
        fs_to_ds_valid = 1'b1; fs_pc = 64'h8000; fs_inst = enc_r(7'd0, 5'd5, 5'd3, 3'b000, 5'd4, 7'h33);
        @(posedge clk); #1;
        fs_to_ds_valid = 1'b0;
        @(negedge clk);
        chk("rs_stalled", 64'(ds_allow_in), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_fwd();
        @(negedge clk);
        chk("rs_to_es_valid", 64'(ds_to_es_valid), 64'd0);
        chk("rs_allow_in",    64'(ds_allow_in),    64'd1);
        chk("rs_pc",          ds_pc,               64'd0);
        chk("rs_inst",        64'(ds_inst),        64'h13);

        repeat (2) @(posedge clk);
        chk("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on posedge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: fs_to_ds_valid  in  1  fetch stage holds a valid instruction; fs_pc  in  64  its PC; fs_inst  in  32  its encoding.
REQ-004 SHALL have: ds_allow_in  out  1  decode can accept from fetch this cycle.
REQ-005 SHALL have: id_inst_cancel  in  1  fetch-side cancel; discard the instruction being accepted this cycle.
REQ-006 SHALL have: wb_flush  in  1  exception/return flush from writeback; kills decode contents.
REQ-007 SHALL have: rf_raddr1, rf_raddr2  out  5  register-file read addresses; rf_rdata1, rf_rdata2  in  64  combinational read data.
REQ-008 SHALL have: es_fwd_valid/ms_fwd_valid/ws_fwd_valid  in  1; es_dest/ms_dest/ws_dest  in  5; es_data/ms_data/ws_data  in  64; es_is_load  in  1  EX holds a load.
REQ-009 SHALL have: ds_to_es_valid  out  1; es_allow_in  in  1; ds_pc  out  64; ds_inst  out  32; ds_rs1_val, ds_rs2_val, ds_imm  out  64.
REQ-010 SHALL have: br_taken  out  1  redirect pulse to fetch; br_target  out  64  redirect address.

Function
REQ-011 SHALL hold one instruction in registers ds_valid/ds_pc_r/ds_inst_r; ds_allow_in = !ds_valid || (ds_ready_go && es_allow_in).
REQ-012 SHALL, when ds_allow_in, load ds_valid <= fs_to_ds_valid && !id_inst_cancel and capture fs_pc/fs_inst on fs_to_ds_valid.
REQ-013 SHALL clear ds_valid on wb_flush regardless of other inputs (flush wins over load); ds_to_es_valid = ds_valid && ds_ready_go && !wb_flush.
REQ-014 SHALL drive rf_raddr1 = inst[19:15], rf_raddr2 = inst[24:20] from the registered instruction.
REQ-015 SHALL forward per source with priority EX > MEM > WB > regfile, matching dest == raddr, fwd_valid high, dest != 0; source x0 always reads 0.
REQ-016 SHALL mark rs1 used for all opcodes except LUI, AUIPC, JAL; rs2 used only for OP, OP-32, BRANCH, STORE.
REQ-017 SHALL deassert ds_ready_go (load-use stall) when es_is_load && es_fwd_valid && es_dest != 0 and es_dest matches a used source; stall holds pc/inst unchanged.
REQ-018 SHALL generate ds_imm sign-extended to 64 bits by format: I (OP-IMM, OP-IMM-32, LOAD, JALR), S, B, U, J; zero for R-type.
REQ-019 SHALL compute branch conditions BEQ/BNE/BLT/BGE (signed), BLTU/BGEU (unsigned) on forwarded 64-bit operands.
REQ-020 SHALL set br_target: branch/JAL = pc + imm; JALR = (rs1 + imm) & ~64'h1; 64-bit wrap-around, no overflow detection.
REQ-021 SHALL assert br_taken for exactly one cycle, only when ds_valid && ds_ready_go && es_allow_in && !wb_flush and the instruction is JAL, JALR, or a taken branch.
REQ-022 SHALL never assert br_taken during a load-use stall or EX backpressure; redirect occurs in the handoff cycle.
REQ-023 SHALL pass ds_pc/ds_inst unchanged to EX; outputs to EX hold stable while ds_to_es_valid && !es_allow_in.

Reset
REQ-024 SHALL on rst: ds_valid = 0, ds_pc_r = 0, ds_inst_r = 32'h00000013 (NOP).
REQ-025 SHALL with ds_valid = 0 drive ds_to_es_valid = 0, br_taken = 0, ds_allow_in = 1; rst mid-stall discards the held instruction.

Structure
REQ-026 SHALL take opcode/funct3 constants, NOP encoding and PC_ENTRY from shared define.v.
REQ-027 SHALL place comparison and target computation in one sub-module id_br_unit; forwarding, immediate and hazard logic remain in id_stage.

Verification
REQ-028 SHALL cover: BEQ x1,x2,+16 at pc 0x80000000, x1=x2=5 -> one-cycle br_taken, br_target 0x80000010.
REQ-029 SHALL cover: es_is_load, es_dest=3, ADD x4,x3,x5 in decode -> ds_ready_go 0, ds_allow_in 0 for one cycle; next cycle es_data forwarded from MEM.
REQ-030 SHALL cover: es, ms, ws all dest=7 with data 1/2/3, rs1=x7 -> ds_rs1_val 1; all dest=0 -> ds_rs1_val 0.
REQ-031 SHALL cover: JALR x0,-3(x1) with x1=0x80000100 -> br_target 0x800000FC (bit0 cleared).
REQ-032 SHALL cover: wb_flush with fs_to_ds_valid=1 same cycle -> ds_valid 0 next cycle, no br_taken; id_inst_cancel with valid fetch -> instruction dropped.
REQ-033 SHALL cover: es_allow_in=0 for 3 cycles with taken JAL -> outputs stable, br_taken asserted only in cycle es_allow_in returns.
